// File: rtl/aes128_dec_iter_ctrl_pkg.sv
// Shared types and AES-128 inverse-round primitives for the iterative decryption engine.
package aes128_dec_iter_ctrl_pkg;
  localparam int AES_NR = 10;
  localparam int AES_KW = 128;
  localparam int AES_DW = 128;

  typedef enum logic [2:0] {
    S_NOKEY = 3'd0,
    S_KEXP  = 3'd1,
    S_IDLE  = 3'd2,
    S_ROUND = 3'd3,
    S_FINAL = 3'd4,
    S_OUT   = 3'd5
  } state_e;

  typedef logic [AES_KW-1:0] rk_arr_t [0:AES_NR];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  // Byte k of a block sits at bits [127-8k -: 8]; byte index = row + 4*column.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // One middle inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  function automatic logic [127:0] main2(input logic [127:0] st, input logic [127:0] rk);
    return inv_mix_columns(inv_sub_bytes(inv_shift_rows(st)) ^ rk);
  endfunction

  // Derives round key rnd (1..10) from round key rnd-1.
  function automatic logic [127:0] key_expansion(input logic [127:0] prev, input logic [3:0] rnd);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    {w0, w1, w2, w3} = prev;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes128_dec_iter_ctrl_rkey_store.sv
// Round-key register file: 11 x 128 bits, one write port, two asynchronous read ports.
module aes128_dec_iter_ctrl_rkey_store
  import aes128_dec_iter_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [3:0]        widx_i,
  input  logic [AES_KW-1:0] wdata_i,
  input  logic [3:0]        ridx_a_i,
  input  logic [3:0]        ridx_b_i,
  output logic [AES_KW-1:0] rdata_a_o,
  output logic [AES_KW-1:0] rdata_b_o
);
  rk_arr_t rk_q;

  // Key slots are wiped on reset so a partially expanded schedule never survives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rk_q <= '{default: '0};
    end else if (we_i && (widx_i <= 4'(AES_NR))) begin
      rk_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (ridx_a_i <= 4'(AES_NR)) ? rk_q[ridx_a_i] : '0;
  assign rdata_b_o = (ridx_b_i <= 4'(AES_NR)) ? rk_q[ridx_b_i] : '0;
endmodule

// File: rtl/aes128_dec_iter_ctrl.sv
// Iterative AES-128 decryption controller: one inverse-round datapath and one key
// expansion step reused across all rounds, with valid/ready handshakes on both sides.
module aes128_dec_iter_ctrl
  import aes128_dec_iter_ctrl_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = AES_KW,
  parameter int DW = AES_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] key_in,
  input  logic          key_load,
  output logic          key_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_out,
  output logic          busy
);
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AES_DW-1:0] st_q, st_d;
  logic [AES_DW-1:0] dout_q, dout_d;
  logic              ovld_q, ovld_d;
  logic              rk_we;
  logic [3:0]        rk_widx, ridx_a, ridx_b;
  logic [AES_KW-1:0] rk_wdata, rka, rkb, fin;

  aes128_dec_iter_ctrl_rkey_store u_rkey (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (rk_we),
    .widx_i    (rk_widx),
    .wdata_i   (rk_wdata),
    .ridx_a_i  (ridx_a),
    .ridx_b_i  (ridx_b),
    .rdata_a_o (rka),
    .rdata_b_o (rkb)
  );

  // State register; illegal encodings fall back to S_NOKEY via the next-state default.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_NOKEY;
    else     state_q <= state_d;
  end

  // Next-state: a block in IDLE wins over a simultaneous key_load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NOKEY: if (key_load) state_d = S_KEXP;
      S_KEXP:  if (cnt_q == 4'(NR)) state_d = S_IDLE;
      S_IDLE:  begin
        if (in_valid)      state_d = S_ROUND;
        else if (key_load) state_d = S_KEXP;
      end
      S_ROUND: if (cnt_q == 4'd1) state_d = S_FINAL;
      S_FINAL: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_NOKEY;
    endcase
  end

  // Key-store read addresses: port A follows the counter (previous key while expanding),
  // port B supplies the whitening key rk[10] or the final key rk[0].
  always_comb begin
    ridx_a = cnt_q;
    ridx_b = 4'(NR);
    if (state_q == S_KEXP)  ridx_a = cnt_q - 4'd1;
    if (state_q == S_FINAL) ridx_b = 4'd0;
  end

  // Datapath and key-store write control for each state.
  always_comb begin
    cnt_d    = cnt_q;
    st_d     = st_q;
    dout_d   = dout_q;
    ovld_d   = ovld_q;
    rk_we    = 1'b0;
    rk_widx  = cnt_q;
    rk_wdata = key_in;
    fin      = inv_sub_bytes(inv_shift_rows(st_q)) ^ rkb;
    case (state_q)
      S_NOKEY: begin
        if (key_load) begin
          rk_we   = 1'b1;
          rk_widx = 4'd0;
          cnt_d   = 4'd1;
        end
      end
      S_KEXP: begin
        rk_we    = 1'b1;
        rk_wdata = key_expansion(rka, cnt_q);
        cnt_d    = (cnt_q == 4'(NR)) ? 4'd0 : cnt_q + 4'd1;
      end
      S_IDLE: begin
        if (in_valid) begin
          st_d  = data_in ^ rkb;
          cnt_d = 4'(NR - 1);
        end else if (key_load) begin
          rk_we   = 1'b1;
          rk_widx = 4'd0;
          cnt_d   = 4'd1;
        end
      end
      S_ROUND: begin
        st_d  = main2(st_q, rka);
        cnt_d = cnt_q - 4'd1;
      end
      S_FINAL: begin
        st_d   = fin;
        dout_d = fin;
        ovld_d = 1'b1;
      end
      S_OUT: begin
        if (out_ready) ovld_d = 1'b0;
      end
      default: begin
        cnt_d = 4'd0;
      end
    endcase
  end

  // Control and visible outputs return to known values on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= '0;
      ovld_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      ovld_q <= ovld_d;
    end
  end

  // Working cipher state; only meaningful between accept and S_FINAL, so never reset.
  always_ff @(posedge clk) begin
    st_q <= st_d;
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    key_ready = (state_q == S_IDLE);
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_KEXP) || (state_q == S_ROUND) ||
                (state_q == S_FINAL) || (state_q == S_OUT);
    out_valid = ovld_q;
    data_out  = dout_q;
  end
endmodule

// File: tb/tb_aes128_dec_iter_ctrl.sv
// Scoreboard bench: random plaintexts are encrypted by a forward-cipher model and the
// engine must return them; FIPS-197 C.1 vectors anchor the absolute values.
module tb_aes128_dec_iter_ctrl;
  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0, data_in = '0, data_out;
  logic         key_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic         key_ready, in_ready, out_valid, busy;
  logic [127:0] rk10;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;
  int or_mode = 0;  // 0 random, 1 hold low, 2 hold high

  typedef struct { logic [127:0] pt; int rise; } exp_t;
  exp_t sb[$];
  logic [7:0] sbox_t [256];

  aes128_dec_iter_ctrl dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  assign rk10 = dut.u_rkey.rk_q[10];

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  always @(posedge clk) begin
    #2;
    if (or_mode == 1)      out_ready = 1'b0;
    else if (or_mode == 2) out_ready = 1'b1;
    else                   out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event did not happen as required", name);
  endtask

  // ---------------- reference model (forward cipher) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from the generator-3 walk: p runs over 3^i, q tracks its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] b;
    b = pt ^ model_rk(key, 0);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox_t[b[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        if (rnd != 10) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int k = 0; k < 16; k++) b[127-8*k -: 8] = s[k];
      b = b ^ model_rk(key, rnd);
    end
    return b;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- monitor ----------------
  logic         prev_ov = 1'b0;
  logic         hold_chk = 1'b0;
  logic [127:0] prev_do = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_ov  = 1'b0;
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_out_valid", 128'(out_valid), 128'(1));
        chk("hold_data_out", data_out, prev_do);
        chk("hold_in_ready", 128'(in_ready), 128'(0));
      end
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) fail("unexpected_out_valid");
        else chk_i("out_latency", edges, sb[0].rise);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("plaintext", data_out, e.pt);
      end
      hold_chk = out_valid && !out_ready;
      prev_do  = data_out;
      prev_ov  = out_valid;
    end
  end

  // ---------------- stimulus tasks (entered at a falling edge) ----------------
  task automatic send(input logic [127:0] ct, input logic [127:0] pt, output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    in_valid = 1'b1;
    data_in = ct;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (in_ready) begin
        acc = edges + 1;
        sb.push_back('{pt, acc + 10});
        ok = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    data_in = rnd128();
    if (!ok) fail("accept_timeout");
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (!(sb.size() == 0 && in_ready) && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (i >= 400) fail("idle_timeout");
  endtask

  task automatic load_key(input logic [127:0] k);
    int  kacc;
    bit  seen;
    seen = 1'b0;
    key_load = 1'b1;
    key_in = k;
    kacc = edges + 1;
    @(negedge clk);
    key_load = 1'b0;
    chk("kexp_busy", 128'(busy), 128'(1));
    chk("kexp_key_ready", 128'(key_ready), 128'(0));
    for (int i = 0; i < 40; i++) begin
      if (key_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (seen) chk_i("key_ready_latency", edges, kacc + 10);
    else      fail("key_ready_timeout");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc, prev_acc;
    bit any_ready;
    logic [127:0] k, pt;
    build_sbox();

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_key_ready", 128'(key_ready), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_data_out", data_out, 128'(0));

    // No key: blocks must not be taken.
    any_ready = 1'b0;
    in_valid = 1'b1;
    data_in = C1_CT;
    repeat (50) begin
      @(negedge clk);
      if (in_ready) any_ready = 1'b1;
    end
    in_valid = 1'b0;
    chk("nokey_in_ready", 128'(any_ready), 128'(0));

    load_key(C1_KEY);
    chk("c1_rk10", rk10, C1_RK10);

    // C.1 with downstream stalled for 5 cycles.
    or_mode = 1;
    send(C1_CT, C1_PT, acc);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_in_ready", 128'(in_ready), 128'(0));
    end
    or_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", 128'(in_ready), 128'(1));
    chk("release_out_valid", 128'(out_valid), 128'(0));
    or_mode = 0;

    // key_load while rounds are running is ignored.
    send(C1_CT, C1_PT, acc);
    repeat (3) @(negedge clk);
    key_load = 1'b1;
    key_in = rnd128();
    @(negedge clk);
    key_load = 1'b0;
    chk("midround_busy", 128'(busy), 128'(1));
    chk("midround_key_ready", 128'(key_ready), 128'(0));
    wait_idle();
    chk("midround_rk10", rk10, C1_RK10);

    // key_load and in_valid together: the block wins.
    key_load = 1'b1;
    key_in = rnd128();
    in_valid = 1'b1;
    data_in = C1_CT;
    chk("same_cycle_in_ready", 128'(in_ready), 128'(1));
    sb.push_back('{C1_PT, edges + 11});
    @(negedge clk);
    key_load = 1'b0;
    in_valid = 1'b0;
    chk("same_cycle_busy", 128'(busy), 128'(1));
    wait_idle();
    chk("same_cycle_key_ready", 128'(key_ready), 128'(1));
    chk("same_cycle_rk10", rk10, C1_RK10);

    // Random keys and plaintexts; first key runs with out_ready always high.
    for (int kk = 0; kk < 4; kk++) begin
      wait_idle();
      k = rnd128();
      or_mode = (kk == 0) ? 2 : 0;
      load_key(k);
      chk("rand_rk10", rk10, model_rk(k, 10));
      prev_acc = -1;
      for (int j = 0; j < 5; j++) begin
        pt = rnd128();
        send(model_enc(pt, k), pt, acc);
        if (kk == 0 && j > 0) chk_i("throughput", acc - prev_acc, 12);
        prev_acc = acc;
      end
    end
    wait_idle();
    or_mode = 0;

    // Reset in the middle of round 5, then recover with a fresh key load.
    load_key(C1_KEY);
    send(C1_CT, C1_PT, acc);
    while (edges < acc + 4) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_key_ready", 128'(key_ready), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_data_out", data_out, 128'(0));
    chk("midrst_rk10", rk10, 128'(0));
    rst = 1'b0;
    @(negedge clk);
    load_key(C1_KEY);
    send(C1_CT, C1_PT, acc);
    wait_idle();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
